// File: rtl/param_data_ram.sv
// Single-port synchronous RAM with registered read data and an optional
// post-reset clear sweep that zeroes every word before accepting accesses.
module param_data_ram #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned RDW_MODE       = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  ready
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] clear_ptr, clear_ptr_next;
  logic [DATA_WIDTH-1:0] data_out_next;
  logic                  rd_valid_next;
  logic                  ready_next;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RESET_STATE;
      clear_ptr <= '0;
      data_out  <= '0;
      rd_valid  <= 1'b0;
      ready     <= 1'b0;
    end else begin
      state     <= state_next;
      clear_ptr <= clear_ptr_next;
      data_out  <= data_out_next;
      rd_valid  <= rd_valid_next;
      ready     <= ready_next;
    end
  end

  // Next-state, memory port steering and read-data selection
  always_comb begin
    state_next     = state;
    clear_ptr_next = clear_ptr;
    data_out_next  = data_out;
    rd_valid_next  = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = address;
    mem_wdata      = data_in;

    case (state)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_addr  = clear_ptr;
        mem_wdata = '0;
        // Leave RUN-bound before the pointer could wrap past the last word
        if (clear_ptr == LAST_ADDR) begin
          state_next = ST_RUN;
        end else begin
          clear_ptr_next = clear_ptr + ADDR_WIDTH'(1);
        end
      end
      ST_RUN: begin
        if (en && ready) begin
          rd_valid_next = 1'b1;
          mem_we        = write_enable;
          if (write_enable && (RDW_MODE != 0)) begin
            data_out_next = data_in;
          end else begin
            data_out_next = mem[address];
          end
        end
      end
      default: state_next = RESET_STATE;
    endcase

    ready_next = (state_next == ST_RUN);
  end

  // Storage array; reset suppresses any same-cycle write
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_param_data_ram.sv
// Directed bench for param_data_ram: default read-first 1K x 8, a write-first
// 16 x 8 copy sharing its stimulus, and a 16 x 16 instance without clear.
module tb_param_data_ram;

  logic        clk;
  logic        rst;
  logic        en;
  logic        we;
  logic [9:0]  addr;
  logic [7:0]  din;
  logic [7:0]  dout_a, dout_b;
  logic        valid_a, valid_b, ready_a, ready_b;

  logic        rst_c, en_c, we_c;
  logic [3:0]  addr_c;
  logic [15:0] din_c, dout_c;
  logic        valid_c, ready_c;

  int checks = 0;
  int errors = 0;

  param_data_ram u_a (
    .clk(clk), .rst(rst), .en(en), .write_enable(we), .address(addr),
    .data_in(din), .data_out(dout_a), .rd_valid(valid_a), .ready(ready_a)
  );

  param_data_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u_b (
    .clk(clk), .rst(rst), .en(en), .write_enable(we), .address(addr[3:0]),
    .data_in(din), .data_out(dout_b), .rd_valid(valid_b), .ready(ready_b)
  );

  param_data_ram #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .RDW_MODE(0), .CLEAR_ON_RESET(0)) u_c (
    .clk(clk), .rst(rst_c), .en(en_c), .write_enable(we_c), .address(addr_c),
    .data_in(din_c), .data_out(dout_c), .rd_valid(valid_c), .ready(ready_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       en;
    logic       we;
    logic [9:0] addr;
    logic [7:0] din;
    logic       vld;
    logic [7:0] ea;
    logic [7:0] eb;
  } vec_t;

  vec_t vecs [19];
  int   cyc;
  int   rb;

  initial begin
    // en, we, addr, din, rd_valid, data_out(read-first), data_out(write-first)
    vecs[0]  = '{1'b1, 1'b0, 10'd0,    8'h00, 1'b1, 8'h00, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 10'd512,  8'h00, 1'b1, 8'h00, 8'h00};
    vecs[2]  = '{1'b1, 1'b0, 10'd1023, 8'h00, 1'b1, 8'h00, 8'h00};
    vecs[3]  = '{1'b0, 1'b0, 10'd7,    8'h00, 1'b0, 8'h00, 8'h00};
    vecs[4]  = '{1'b1, 1'b1, 10'd1,    8'hFF, 1'b1, 8'h00, 8'hFF};
    vecs[5]  = '{1'b1, 1'b1, 10'd2,    8'hAA, 1'b1, 8'h00, 8'hAA};
    vecs[6]  = '{1'b1, 1'b1, 10'd3,    8'hF0, 1'b1, 8'h00, 8'hF0};
    vecs[7]  = '{1'b1, 1'b0, 10'd1,    8'h00, 1'b1, 8'hFF, 8'hFF};
    vecs[8]  = '{1'b1, 1'b0, 10'd2,    8'h00, 1'b1, 8'hAA, 8'hAA};
    vecs[9]  = '{1'b1, 1'b0, 10'd3,    8'h00, 1'b1, 8'hF0, 8'hF0};
    vecs[10] = '{1'b1, 1'b1, 10'd5,    8'h11, 1'b1, 8'h00, 8'h11};
    vecs[11] = '{1'b0, 1'b0, 10'd5,    8'h00, 1'b0, 8'h00, 8'h11};
    vecs[12] = '{1'b1, 1'b1, 10'd5,    8'h22, 1'b1, 8'h11, 8'h22};
    vecs[13] = '{1'b1, 1'b0, 10'd5,    8'h00, 1'b1, 8'h22, 8'h22};
    vecs[14] = '{1'b1, 1'b0, 10'd4,    8'h00, 1'b1, 8'h00, 8'h00};
    vecs[15] = '{1'b0, 1'b1, 10'd6,    8'h55, 1'b0, 8'h00, 8'h00};
    vecs[16] = '{1'b1, 1'b0, 10'd6,    8'h00, 1'b1, 8'h00, 8'h00};
    vecs[17] = '{1'b1, 1'b1, 10'd1023, 8'h3C, 1'b1, 8'h00, 8'h3C};
    vecs[18] = '{1'b1, 1'b0, 10'd1023, 8'h00, 1'b1, 8'h3C, 8'h3C};

    rst = 1'b1; en = 1'b0; we = 1'b0; addr = '0; din = '0;
    rst_c = 1'b1; en_c = 1'b0; we_c = 1'b0; addr_c = '0; din_c = '0;

    // Reset state
    @(negedge clk);
    chk("reset_ready", 32'(ready_a), 32'd0);
    chk("reset_valid", 32'(valid_a), 32'd0);
    chk("reset_dout", 32'(dout_a), 32'd0);

    // Release reset with a write to 4 that must be dropped while clearing
    rst = 1'b0; en = 1'b1; we = 1'b1; addr = 10'd4; din = 8'h77;
    cyc = 0; rb = 0;
    while (!ready_a && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk("drop_valid_a", 32'(valid_a), 32'd0);
        chk("drop_valid_b", 32'(valid_b), 32'd0);
        en = 1'b0; we = 1'b0;
      end
      if (ready_b && rb == 0) rb = cyc;
    end
    chk("clear_cycles_a", 32'(cyc), 32'd1024);
    chk("clear_cycles_b", 32'(rb), 32'd16);

    // Back-to-back vector table, one access per cycle
    foreach (vecs[i]) begin
      en = vecs[i].en; we = vecs[i].we; addr = vecs[i].addr; din = vecs[i].din;
      @(negedge clk);
      chk($sformatf("v%0d_valid_a", i), 32'(valid_a), 32'(vecs[i].vld));
      chk($sformatf("v%0d_valid_b", i), 32'(valid_b), 32'(vecs[i].vld));
      chk($sformatf("v%0d_dout_a", i), 32'(dout_a), 32'(vecs[i].ea));
      chk($sformatf("v%0d_dout_b", i), 32'(dout_b), 32'(vecs[i].eb));
    end
    en = 1'b0; we = 1'b0;

    // Reset at clear cycle 300 restarts the full sweep
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    chk("mid_clear_ready", 32'(ready_a), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rerst_ready", 32'(ready_a), 32'd0);
    chk("rerst_dout", 32'(dout_a), 32'd0);
    rst = 1'b0;
    cyc = 0;
    while (!ready_a && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("reclear_cycles", 32'(cyc), 32'd1024);
    en = 1'b1; we = 1'b0; addr = 10'd1;
    @(negedge clk);
    chk("reclear_valid", 32'(valid_a), 32'd1);
    chk("reclear_dout_a", 32'(dout_a), 32'd0);
    chk("reclear_dout_b", 32'(dout_b), 32'd0);
    en = 1'b0;

    // No-clear instance: contents survive reset, ready right after release
    chk("c_reset_ready", 32'(ready_c), 32'd0);
    rst_c = 1'b0;
    @(negedge clk);
    chk("c_ready_first", 32'(ready_c), 32'd1);
    en_c = 1'b1; we_c = 1'b1; addr_c = 4'd15; din_c = 16'hBEEF;
    @(negedge clk);
    chk("c_write_valid", 32'(valid_c), 32'd1);
    rst_c = 1'b1; din_c = 16'h1234;
    @(negedge clk);
    chk("c_rst_ready", 32'(ready_c), 32'd0);
    chk("c_rst_valid", 32'(valid_c), 32'd0);
    chk("c_rst_dout", 32'(dout_c), 32'd0);
    rst_c = 1'b0; we_c = 1'b0;
    @(negedge clk);
    chk("c_rel_ready", 32'(ready_c), 32'd1);
    chk("c_rel_valid", 32'(valid_c), 32'd0);
    @(negedge clk);
    chk("c_read_valid", 32'(valid_c), 32'd1);
    chk("c_read_dout", 32'(dout_c), 32'hBEEF);
    en_c = 1'b0;
    @(negedge clk);
    chk("c_idle_valid", 32'(valid_c), 32'd0);
    chk("c_idle_dout", 32'(dout_c), 32'hBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
